replay_mem_responder: RTL and testbench
=======================================

# replay_mem_responder

SPI slave on the Cyclone IV memory board that answers the CPLD's replay-fetch master. Each 8-bit SPI transaction does two things at once:
- It returns the next byte of a recorded sensor-response stream held in an on-board synchronous RAM/ROM.
- It captures the CPU command byte the master forwards on MOSI.

The CPLD then injects the returned bytes into the card CPU in place of the real fingerprint sensor.

## Interface
Parameters:
- ADDR_W, 16, width of replay address pointer
- DEPTH, 16'hFFFF, number of valid replay bytes; addresses >= DEPTH are not read
- FILL, 8'h00, byte returned once the pointer reaches DEPTH
- RESYNC_CMD, 8'hFC, command byte that rewinds the stream

Ports:
- SYSCLK  in  1  system clock; all logic on its rising edge
- resetb  in  1  asynchronous active-low reset
- mem_spi_en  in  1  SPI chip select from master, low active
- mem_spi_clk  in  1  SPI clock, CPOL=0 CPHA=0
- mem_spi_mosi  in  1  master-to-slave data (CPU command byte), MSB first
- mem_spi_miso  out  1  slave-to-master data (replay byte), MSB first
- rd_addr  out  ADDR_W  replay memory read address
- rd_data  in  8  replay memory data, valid 1 SYSCLK after rd_addr
- cmd_valid  out  1  one-cycle pulse: complete command byte received
- cmd_byte  out  8  last complete command byte
- busy  out  1  high while a transaction is in progress (synchronised CS low)
- abort_cnt  out  8  saturating count of truncated transactions

## Operation
- Synchronisation:
  - mem_spi_en, mem_spi_clk and mem_spi_mosi each pass through 2 flops.
  - Edges are detected from the synchronised SCLK and CS, comparing the current and previous sample.
- States: IDLE, SHIFT, DONE.
- IDLE (CS high):
  - mem_spi_miso = 0; bit counter = 0.
  - On CS falling edge: load tx shift register from rd_data, drive tx[7] on MISO, clear rx, go to SHIFT.
- SHIFT:
  - SCLK rising edge: rx <= {rx[6:0], mosi_sync}; bit counter +1.
  - SCLK falling edge: tx <= {tx[6:0], 0`}, so MISO presents the next bit.
  - After the 8th rising edge: cmd_byte <= rx value; cmd_valid pulses for 1 cycle. The bit counter then ignores further SCLK edges.
  - On CS rising edge: go to DONE if bit counter == 8; otherwise increment abort_cnt (saturate at 8'hFF), leave the pointer unchanged and return to IDLE.
- DONE (1 cycle), pointer update:
  - If cmd_byte == RESYNC_CMD: pointer <= 1. By recording convention the response to 0xFC is stored at address 0, and the 0xFC transaction has just served it.
  - Else if pointer < DEPTH: pointer <= pointer + 1.
  - Else: pointer holds at DEPTH.
  - Then return to IDLE.
- Read path:
  - rd_addr is registered and equals the pointer.
  - When pointer >= DEPTH, the tx load uses FILL instead of rd_data.
- Reset (asynchronous, any state, including mid-transaction):
  - State IDLE, pointer 0, rd_addr 0.
  - mem_spi_miso 0, cmd_valid 0, cmd_byte 8'h00, busy 0, abort_cnt 0, tx/rx 0.
  - A transaction interrupted by reset is dropped: no cmd_valid, no pointer change.
- CS rising edge in the same cycle as the 8th SCLK rising edge: the rising edge is processed first and counts, so the transaction completes normally.

## Timing
- Input-to-action latency: 3 SYSCLK (2 sync flops + edge register).
  - MISO first bit valid 3-4 SYSCLK after the CS pin falls.
  - Each subsequent bit valid 3-4 SYSCLK after the SCLK pin falls.
- Master SCLK half-period must be >= 6 SYSCLK. The CPLD master with clk_divider=6 satisfies this.
- CS high gap between transactions must be >= 5 SYSCLK: DONE (1) + rd_addr register (1) + rd_data latency (1) + sync margin (2).
- cmd_valid is asserted 3 SYSCLK after the 8th SCLK rising edge at the pin.
- The pointer advances in the DONE cycle, 4 SYSCLK after the CS pin rises.
- busy follows synchronised CS with 2 SYSCLK latency, rising and falling.

## Test plan
- Sequence test:
  - Stimulus: memory preloaded with 8'hA0+i at address i; reset; 4 transactions sending 8'hFC, 8'hC4, 8'h11, 8'h22.
  - Required: MISO returns A0, A1, A2, A3; cmd_valid pulses 4 times with FC, C4, 11, 22; rd_addr ends at 4.
- Mid-stream resync:
  - Stimulus: after 10 transactions, send 8'hFC, then one more transaction.
  - Required: the FC transaction returns AA; the next returns A1 (pointer rewound to 1).
- Truncated transaction:
  - Stimulus: CS high after 5 SCLK pulses.
  - Required: no cmd_valid; abort_cnt == 1; the next full transaction returns the same byte the truncated one began with.
- End of buffer:
  - Stimulus: DEPTH=3 with 5 transactions (first sends 8'hFC).
  - Required: returns A0, A1, A2, 00, 00; rd_addr holds at 3.
- Reset mid-transaction:
  - Stimulus: assert resetb low after 4 SCLK pulses, release, then a full transaction.
  - Required: all outputs at reset values immediately; the next transaction returns A0.
- Timing margin:
  - Stimulus: SCLK half-period of exactly 6 SYSCLK with the minimum 5-cycle CS gap, 256 back-to-back transactions.
  - Required: all received bytes and returned bytes are bit-exact; abort_cnt == 0.

Source files
------------

// File: rtl/replay_mem_responder_if.sv
// SPI pin bundle between the CPLD replay-fetch master and the memory-board responder.
interface replay_mem_responder_if;
    logic mem_spi_en;
    logic mem_spi_clk;
    logic mem_spi_mosi;
    logic mem_spi_miso;

    modport master (output mem_spi_en, output mem_spi_clk, output mem_spi_mosi, input mem_spi_miso);
    modport slave  (input mem_spi_en, input mem_spi_clk, input mem_spi_mosi, output mem_spi_miso);
endinterface

// File: rtl/replay_mem_responder.sv
// SPI slave that streams recorded sensor bytes out of replay memory on MISO while
// capturing the forwarded CPU command byte from MOSI.
module replay_mem_responder #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH      = 16'hFFFF,
    parameter logic [7:0]  FILL       = 8'h00,
    parameter logic [7:0]  RESYNC_CMD = 8'hFC
) (
    input  logic                  SYSCLK,
    input  logic                  resetb,
    replay_mem_responder_if.slave spi,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [7:0]            rd_data,
    output logic                  cmd_valid,
    output logic [7:0]            cmd_byte,
    output logic                  busy,
    output logic [7:0]            abort_cnt
);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t            state;
    logic [1:0]        en_s, sclk_s, mosi_s;
    logic              en_q, sclk_q;
    logic [ADDR_W-1:0] ptr;
    logic [7:0]        tx, rx;
    logic [3:0]        bit_cnt;
    logic              miso;

    logic       cs_fall, cs_rise, sclk_rise, sclk_fall, take_bit;
    logic [7:0] rx_next, load_byte;
    logic [3:0] bit_cnt_nx;

    always_comb begin
        cs_fall    = en_q & ~en_s[1];
        cs_rise    = ~en_q & en_s[1];
        sclk_rise  = ~sclk_q & sclk_s[1];
        sclk_fall  = sclk_q & ~sclk_s[1];
        // bits past the eighth are ignored until CS returns high
        take_bit   = sclk_rise && (bit_cnt != 4'd8);
        rx_next    = {rx[6:0], mosi_s[1]};
        bit_cnt_nx = take_bit ? bit_cnt + 4'd1 : bit_cnt;
        load_byte  = (ptr >= DEPTH_A) ? FILL : rd_data;
    end

    assign spi.mem_spi_miso = miso;

    always_ff @(posedge SYSCLK or negedge resetb) begin
        if (!resetb) begin
            en_s      <= 2'b11;
            sclk_s    <= 2'b00;
            mosi_s    <= 2'b00;
            en_q      <= 1'b1;
            sclk_q    <= 1'b0;
            state     <= S_IDLE;
            ptr       <= '0;
            rd_addr   <= '0;
            tx        <= 8'h00;
            rx        <= 8'h00;
            bit_cnt   <= 4'd0;
            miso      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_byte  <= 8'h00;
            busy      <= 1'b0;
            abort_cnt <= 8'h00;
        end else begin
            en_s      <= {en_s[0], spi.mem_spi_en};
            sclk_s    <= {sclk_s[0], spi.mem_spi_clk};
            mosi_s    <= {mosi_s[0], spi.mem_spi_mosi};
            en_q      <= en_s[1];
            sclk_q    <= sclk_s[1];
            busy      <= ~en_s[1];
            rd_addr   <= ptr;
            cmd_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    miso    <= 1'b0;
                    bit_cnt <= 4'd0;
                    if (cs_fall) begin
                        tx    <= load_byte;
                        miso  <= load_byte[7];
                        rx    <= 8'h00;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (take_bit) begin
                        rx      <= rx_next;
                        bit_cnt <= bit_cnt_nx;
                        if (bit_cnt == 4'd7) begin
                            cmd_byte  <= rx_next;
                            cmd_valid <= 1'b1;
                        end
                    end
                    if (sclk_fall) begin
                        tx   <= {tx[6:0], 1'b0};
                        miso <= tx[6];
                    end
                    // a final SCLK rise landing with CS rise still counts
                    if (cs_rise) begin
                        miso <= 1'b0;
                        if (bit_cnt_nx == 4'd8) begin
                            state <= S_DONE;
                        end else begin
                            if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
                            state <= S_IDLE;
                        end
                    end
                end
                S_DONE: begin
                    // recording convention: the 0xFC response lives at address 0
                    if (cmd_byte == RESYNC_CMD) ptr <= ADDR_W'(1);
                    else if (ptr < DEPTH_A)     ptr <= ptr + ADDR_W'(1);
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_replay_mem_responder.sv
// Directed bench: drives two responders (full depth and DEPTH=3) from one SPI master
// and checks them against a transaction-level model of the replay stream.
module tb_replay_mem_responder;
    logic SYSCLK = 1'b0;
    logic resetb = 1'b0;
    logic cs = 1'b1, sclk = 1'b0, mosi = 1'b0;

    replay_mem_responder_if bus0();
    replay_mem_responder_if bus3();
    assign bus0.mem_spi_en = cs;   assign bus3.mem_spi_en = cs;
    assign bus0.mem_spi_clk = sclk; assign bus3.mem_spi_clk = sclk;
    assign bus0.mem_spi_mosi = mosi; assign bus3.mem_spi_mosi = mosi;

    logic [15:0] rd_addr0, rd_addr3;
    logic [7:0]  rd_data0, rd_data3, cmd_byte0, cmd_byte3, abort0, abort3;
    logic        cmd_valid0, cmd_valid3, busy0, busy3;

    replay_mem_responder dut0 (
        .SYSCLK(SYSCLK), .resetb(resetb), .spi(bus0), .rd_addr(rd_addr0), .rd_data(rd_data0),
        .cmd_valid(cmd_valid0), .cmd_byte(cmd_byte0), .busy(busy0), .abort_cnt(abort0));
    replay_mem_responder #(.DEPTH(3)) dut3 (
        .SYSCLK(SYSCLK), .resetb(resetb), .spi(bus3), .rd_addr(rd_addr3), .rd_data(rd_data3),
        .cmd_valid(cmd_valid3), .cmd_byte(cmd_byte3), .busy(busy3), .abort_cnt(abort3));

    always #5 SYSCLK = ~SYSCLK;

    // replay memory: byte at address i is A0+i, one-cycle read latency
    always_ff @(posedge SYSCLK) begin
        rd_data0 <= 8'hA0 + rd_addr0[7:0];
        rd_data3 <= 8'hA0 + rd_addr3[7:0];
    end

    int total = 0;
    int bad = 0;
    int mptr[2];
    int mabort[2];
    int mdepth[2] = '{65535, 3};
    logic [7:0] cmdq0[$];
    logic [7:0] cmdq3[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_ret(input int k);
        logic [7:0] b;
        b = 8'hA0 + 8'(mptr[k]);
        return (mptr[k] < mdepth[k]) ? b : 8'h00;
    endfunction

    // every command pulse must match the next byte the master completed
    always @(negedge SYSCLK) begin
        if (resetb) begin
            if (cmd_valid0) begin
                if (cmdq0.size() == 0) check("cmd_valid0_spurious", 1, 0);
                else check("cmd_byte0", {24'h0, cmd_byte0}, {24'h0, cmdq0.pop_front()});
            end
            if (cmd_valid3) begin
                if (cmdq3.size() == 0) check("cmd_valid3_spurious", 1, 0);
                else check("cmd_byte3", {24'h0, cmd_byte3}, {24'h0, cmdq3.pop_front()});
            end
        end
    end

    task automatic xfer(input logic [7:0] txb, input int npulses, input int h, input int gap,
                        input bit same_edge, output logic [7:0] r0, output logic [7:0] r3);
        logic [7:0] e0, e3;
        bit cs_done;
        e0 = model_ret(0);
        e3 = model_ret(1);
        r0 = 8'h00;
        r3 = 8'h00;
        cs_done = 1'b0;
        if (npulses == 8) begin
            cmdq0.push_back(txb);
            cmdq3.push_back(txb);
        end
        cs = 1'b0;
        mosi = txb[7];
        repeat (h) @(negedge SYSCLK);
        check("busy_during", {30'h0, busy0, busy3}, 32'h3);
        for (int i = 0; i < npulses; i++) begin
            r0 = {r0[6:0], bus0.mem_spi_miso};
            r3 = {r3[6:0], bus3.mem_spi_miso};
            sclk = 1'b1;
            if (same_edge && i == npulses - 1) begin
                cs = 1'b1;
                cs_done = 1'b1;
            end
            repeat (h) @(negedge SYSCLK);
            sclk = 1'b0;
            if (i < 7) mosi = txb[6-i];
            if (!cs_done) repeat (h) @(negedge SYSCLK);
        end
        cs = 1'b1;
        repeat (gap) @(negedge SYSCLK);
        for (int k = 0; k < 2; k++) begin
            if (npulses == 8) begin
                if (txb == 8'hFC) mptr[k] = 1;
                else if (mptr[k] < mdepth[k]) mptr[k]++;
            end else if (mabort[k] < 255) begin
                mabort[k]++;
            end
        end
        if (npulses == 8) begin
            check("miso_byte0", {24'h0, r0}, {24'h0, e0});
            check("miso_byte3", {24'h0, r3}, {24'h0, e3});
            check("cmd_pending", cmdq0.size() + cmdq3.size(), 0);
        end
        check("rd_addr0", {16'h0, rd_addr0}, mptr[0]);
        check("rd_addr3", {16'h0, rd_addr3}, mptr[1]);
        check("abort0", {24'h0, abort0}, mabort[0]);
        check("abort3", {24'h0, abort3}, mabort[1]);
        check("busy_idle", {30'h0, busy0, busy3}, 32'h0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rd_addr"}, {rd_addr0, rd_addr3}, 32'h0);
        check({tag, "_miso"}, {30'h0, bus0.mem_spi_miso, bus3.mem_spi_miso}, 32'h0);
        check({tag, "_cmd_valid"}, {30'h0, cmd_valid0, cmd_valid3}, 32'h0);
        check({tag, "_cmd_byte"}, {16'h0, cmd_byte0, cmd_byte3}, 32'h0);
        check({tag, "_busy"}, {30'h0, busy0, busy3}, 32'h0);
        check({tag, "_abort"}, {16'h0, abort0, abort3}, 32'h0);
    endtask

    initial begin
        logic [7:0] r0, r3, part;
        mptr = '{0, 0};
        mabort = '{0, 0};
        repeat (3) @(negedge SYSCLK);
        check_reset_vals("reset");
        resetb = 1'b1;
        repeat (4) @(negedge SYSCLK);

        // sequence and end-of-buffer
        xfer(8'hFC, 8, 8, 6, 0, r0, r3);
        check("seq_0", {r0, r3}, 32'hA0A0);
        xfer(8'hC4, 8, 8, 6, 0, r0, r3);
        check("seq_1", {r0, r3}, 32'hA1A1);
        xfer(8'h11, 8, 8, 6, 0, r0, r3);
        check("seq_2", {r0, r3}, 32'hA2A2);
        xfer(8'h22, 8, 8, 6, 0, r0, r3);
        check("seq_3", {r0, r3}, 32'hA300);
        check("seq_rd_addr", {16'h0, rd_addr0}, 32'h4);
        xfer(8'h33, 8, 8, 6, 0, r0, r3);
        check("eob_fill", {24'h0, r3}, 32'h00);
        check("eob_rd_addr_hold", {16'h0, rd_addr3}, 32'h3);

        // mid-stream resync after 10 transactions
        for (int i = 0; i < 5; i++) xfer(8'h40 + 8'(i), 8, 8, 6, 0, r0, r3);
        xfer(8'hFC, 8, 8, 6, 0, r0, r3);
        check("resync_fc", {24'h0, r0}, 32'hAA);
        xfer(8'h5C, 8, 8, 6, 0, r0, r3);
        check("resync_next", {24'h0, r0}, 32'hA1);

        // truncated transaction, then same byte again
        xfer(8'h5A, 5, 8, 6, 0, r0, r3);
        part = r0;
        check("trunc_bits", {27'h0, part[4:0]}, 32'h14);
        check("trunc_abort", {24'h0, abort0}, 32'h1);
        xfer(8'h6B, 8, 8, 6, 0, r0, r3);
        check("trunc_replay", {24'h0, r0}, 32'hA2);
        check("trunc_prefix", {27'h0, r0[7:3]}, {27'h0, part[4:0]});

        // CS rising with the eighth SCLK rise still completes
        xfer(8'h77, 8, 6, 5, 1, r0, r3);
        check("same_edge_rd_addr", {16'h0, rd_addr0}, 32'h4);

        // reset in the middle of a transaction
        cmdq0.push_back(8'h99);
        cmdq3.push_back(8'h99);
        cs = 1'b0;
        mosi = 1'b1;
        repeat (6) @(negedge SYSCLK);
        for (int i = 0; i < 4; i++) begin
            sclk = 1'b1; repeat (6) @(negedge SYSCLK);
            sclk = 1'b0; repeat (6) @(negedge SYSCLK);
        end
        resetb = 1'b0;
        #1;
        check_reset_vals("midreset");
        cmdq0.delete();
        cmdq3.delete();
        mptr = '{0, 0};
        mabort = '{0, 0};
        cs = 1'b1;
        repeat (3) @(negedge SYSCLK);
        resetb = 1'b1;
        repeat (5) @(negedge SYSCLK);
        xfer(8'h12, 8, 6, 5, 0, r0, r3);
        check("after_reset", {r0, r3}, 32'hA0A0);

        // minimum timing: half-period 6, CS gap 5, back to back
        for (int i = 0; i < 256; i++) xfer(8'($urandom_range(0, 255)), 8, 6, 5, 0, r0, r3);
        check("margin_abort", {24'h0, abort0}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
